// File: rtl/led_fade_pwm_if.sv
// LED fade bus: chaser pattern in, PWM drive and activity flag out.
//   led_in  : one-hot pattern from the chaser (asynchronous to clk)
//   led_out : PWM-modulated LED drive (registered)
//   active  : high while any channel still has a non-zero level
// master = pattern source / LED consumer, slave = led_fade_pwm.
interface led_fade_pwm_if #(
  parameter int N = 4
);
  logic [N-1:0] led_in;
  logic [N-1:0] led_out;
  logic         active;

  modport master (output led_in, input led_out, input active);
  modport slave  (input led_in, output led_out, output active);
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: lights each LED at full brightness while its chaser bit is
// high, then fades it out by PWM so a comet tail trails the running light.
// Ports:
//   clk  : main board clock
//   rst  : synchronous reset, active high
//   bus  : led_fade_pwm_if.slave (led_in, led_out, active)
// Optional feature macro: LED_FADE_GAMMA_EN -- squares the level to get the
// PWM duty (approximate gamma 2) at the cost of one extra pipeline stage.

// Per-channel slice: input synchroniser, level register, duty and PWM output.
module led_fade_chan #(
  parameter int W          = 8,
  parameter int DECAY_STEP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         tick,
  input  logic [W-1:0] pwm_cnt,
  output logic         lvl_nz,
  output logic         pwm_o
);
  localparam logic [W-1:0] LVL_MAX = '1;
  localparam logic [W-1:0] STEP    = W'(DECAY_STEP);

  logic [1:0]   sync_q, sync_d;
  logic [W-1:0] level_q, level_d;
  logic         out_q, out_d;

`ifdef LED_FADE_GAMMA_EN
  logic [W-1:0]   duty_q, duty_d;
  logic           full_q, full_d;
  logic [2*W-1:0] sq;
`endif

  always_comb begin
    sync_d = {sync_q[0], din};
    // Attack beats decay when both land on the same cycle.
    level_d = level_q;
    if (sync_q[1])
      level_d = LVL_MAX;
    else if (tick)
      level_d = (level_q > STEP) ? level_q - STEP : '0;
`ifdef LED_FADE_GAMMA_EN
    sq     = (2*W)'(level_q) * (2*W)'(level_q);
    duty_d = sq[2*W-1:W];
    // Full-scale flag travels with the duty so force-on stays aligned.
    full_d = (level_q == LVL_MAX);
    out_d  = full_q | (duty_q > pwm_cnt);
`else
    // Force-on at full scale avoids the 1/2^W dropout at pwm_cnt==max.
    out_d  = (level_q == LVL_MAX) | (level_q > pwm_cnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= '0;
      out_q   <= 1'b0;
`ifdef LED_FADE_GAMMA_EN
      duty_q  <= '0;
      full_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      out_q   <= out_d;
`ifdef LED_FADE_GAMMA_EN
      duty_q  <= duty_d;
      full_q  <= full_d;
`endif
    end
  end

  assign lvl_nz = |level_q;
  assign pwm_o  = out_q;
endmodule

module led_fade_pwm #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int PWM_DIV    = 1,
  parameter int DECAY_DIV  = 250000,
  parameter int DECAY_STEP = 16
) (
  input  logic           clk,
  input  logic           rst,
  led_fade_pwm_if.slave  bus
);
  localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int PCW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DCW-1:0] dec_cnt_q, dec_cnt_d;
  logic [PCW-1:0] pre_q, pre_d;
  logic [W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic           active_q, active_d;
  logic           dec_tick, pwm_wrap;
  logic [N-1:0]   lvl_nz, pwm_o;

  always_comb begin
    dec_tick  = (dec_cnt_q == DCW'(DECAY_DIV - 1));
    dec_cnt_d = dec_tick ? '0 : dec_cnt_q + 1'b1;
    pwm_wrap  = (pre_q == PCW'(PWM_DIV - 1));
    pre_d     = pwm_wrap ? '0 : pre_q + 1'b1;
    pwm_cnt_d = pwm_wrap ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    // Levels sampled before this edge's update: falls a cycle after the last hits 0.
    active_d  = |lvl_nz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q <= '0;
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      active_q  <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      active_q  <= active_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    led_fade_chan #(.W(W), .DECAY_STEP(DECAY_STEP)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .din     (bus.led_in[i]),
      .tick    (dec_tick),
      .pwm_cnt (pwm_cnt_q),
      .lvl_nz  (lvl_nz[i]),
      .pwm_o   (pwm_o[i])
    );
  end

  assign bus.led_out = pwm_o;
  assign bus.active  = active_q;
endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;
`ifdef LED_FADE_GAMMA_EN
  localparam bit GAM = 1'b1;
`else
  localparam bit GAM = 1'b0;
`endif
  localparam int LAT = GAM ? 5 : 4;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  led_fade_pwm_if #(.N(4)) ifa ();
  led_fade_pwm_if #(.N(4)) ifb ();

  // a: short decay period for the fade-step tests
  led_fade_pwm #(.N(4), .W(8), .PWM_DIV(1), .DECAY_DIV(4), .DECAY_STEP(64)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave));
  // b: 255 -> 127 on the first tick, then a long hold to measure PWM duty
  led_fade_pwm #(.N(4), .W(8), .PWM_DIV(1), .DECAY_DIV(1024), .DECAY_STEP(128)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave));

  typedef struct {
    bit         sel;   // 0: dut_a, 1: dut_b
    bit         co;
    bit         ca;
    logic [3:0] eo;
    logic       ea;
    bit         acc;   // add dut_b led_out[0] into the high count
    bit         cmp;   // compare the high count against ec
    int         ec;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   hi_cnt = 0;

  task automatic push(input bit sel, input bit co, input bit ca, input logic [3:0] eo,
                      input logic ea, input bit acc, input bit cmp, input int ec, input string nm);
    exp_t e;
    e.sel = sel; e.co = co; e.ca = ca; e.eo = eo; e.ea = ea;
    e.acc = acc; e.cmp = cmp; e.ec = ec; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic cyc_a(input logic r, input logic [3:0] din, input bit co, input bit ca,
                       input logic [3:0] eo, input logic ea, input string nm);
    @(negedge clk);
    rst_a = r;
    ifa.led_in = din;
    push(1'b0, co, ca, eo, ea, 1'b0, 1'b0, 0, nm);
  endtask

  task automatic cyc_b(input logic r, input logic [3:0] din, input bit co, input bit ca,
                       input logic [3:0] eo, input logic ea, input bit acc, input bit cmp,
                       input int ec, input string nm);
    @(negedge clk);
    rst_b = r;
    ifb.led_in = din;
    push(1'b1, co, ca, eo, ea, acc, cmp, ec, nm);
  endtask

  // Monitor: one scoreboard entry per clock, checked just after the edge.
  initial begin : monitor
    exp_t       e;
    logic [3:0] lo;
    logic       ac;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        lo = e.sel ? ifb.led_out : ifa.led_out;
        ac = e.sel ? ifb.active  : ifa.active;
        if (e.co) begin
          n_chk++;
          if (lo !== e.eo) begin
            n_err++;
            $display("FAIL %s led_out got %b expected %b @%0t", e.nm, lo, e.eo, $time);
          end
        end
        if (e.ca) begin
          n_chk++;
          if (ac !== e.ea) begin
            n_err++;
            $display("FAIL %s active got %b expected %b @%0t", e.nm, ac, e.ea, $time);
          end
        end
        if (e.acc) hi_cnt += int'(ifb.led_out[0]);
        if (e.cmp) begin
          n_chk++;
          if (hi_cnt != e.ec) begin
            n_err++;
            $display("FAIL %s high count got %0d expected %0d", e.nm, hi_cnt, e.ec);
          end
          hi_cnt = 0;
        end
      end
    end
  end

  initial begin : stim
    ifa.led_in = 4'b0000;
    ifb.led_in = 4'b0000;

    // 1: reset with all inputs high, then full-on hold across a whole PWM period
    for (int k = 0; k < 3; k++) cyc_a(1'b1, 4'b1111, 1, 1, 4'b0000, 1'b0, "rst_hold");
    for (int k = 1; k <= 260; k++)
      cyc_a(1'b0, 4'b1111, 1, 1, (k >= LAT) ? 4'b1111 : 4'b0000, k >= 4, "full_on");

    // 2: only channel 0 driven
    for (int k = 0; k < 2; k++) cyc_a(1'b1, 4'b0001, 1, 1, 4'b0000, 1'b0, "rst2");
    for (int k = 1; k <= 12; k++)
      cyc_a(1'b0, 4'b0001, 1, 1, (k >= LAT) ? 4'b0001 : 4'b0000, k >= 4, "ch0_on");

    // 3: drop; levels 191/127/63/0 after edges 16/20/24/28
    for (int k = 13; k <= 30; k++)
      cyc_a(1'b0, 4'b0000, 1, 1,
            ((GAM && k <= 25) || (!GAM && k <= 28)) ? 4'b0001 : 4'b0000, k <= 28, "fade");

    // 5: in_s high only for the edge-36 update, which is also a decay tick
    for (int k = 31; k <= 55; k++)
      cyc_a(1'b0, (k == 34) ? 4'b0001 : 4'b0000, 1, 1,
            ((GAM && k >= 38 && k <= 49) || (!GAM && k >= 37 && k <= 52)) ? 4'b0001 : 4'b0000,
            (k >= 37 && k <= 52), "attack_on_tick");

    // 4: dut_b pulse to 255, decays to 127 at edge 1024, measure one PWM period
    for (int j = 0; j < 2; j++)
      cyc_b(1'b1, 4'b0000, 1, 1, 4'b0000, 1'b0, 0, 0, 0, "b_rst");
    for (int j = 1; j <= 8; j++)
      cyc_b(1'b0, (j <= 3) ? 4'b0001 : 4'b0000, 1, 1,
            (j >= LAT) ? 4'b0001 : 4'b0000, j >= 4, 0, 0, 0, "b_pulse");
    for (int j = 9; j <= 1100; j++)
      cyc_b(1'b0, 4'b0000, 0, 0, 4'b0000, 1'b0, 0, 0, 0, "b_idle");
    for (int j = 1101; j <= 1356; j++)
      cyc_b(1'b0, 4'b0000, 0, 1, 4'b0000, 1'b1, 1, 0, 0, "b_pwm127");
    cyc_b(1'b0, 4'b0000, 0, 0, 4'b0000, 1'b0, 0, 1, GAM ? 63 : 127, "b_duty");

    // 6: reset mid-fade (level 127) must clear everything on the next edge
    for (int j = 0; j < 2; j++)
      cyc_b(1'b1, 4'b0000, 1, 1, 4'b0000, 1'b0, 0, 0, 0, "b_rst_mid");
    for (int j = 0; j < 6; j++)
      cyc_b(1'b0, 4'b0000, 1, 1, 4'b0000, 1'b0, 0, 0, 0, "b_after_rst");

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
